tpu_sequencer: RTL
==================

// Module: tpu_sequencer
// PURPOSE
// - Parametrised multi-cycle instruction sequencer for the systolic-array TPU; replaces the 1-cycle control decoder.
// - Accepts instructions over a valid/ready handshake and expands each into a burst of N row operations.
// - Drives buffer, FIFO, MMU and accumulator strobes plus auto-incrementing addresses; sits between host instruction queue and datapath.
// PARAMETERS
// - OPCODE_BITS   4   opcode field width
// - ADDRA_BITS    8   read-address (UB/WB/ACC) width
// - ADDRB_BITS    8   write-address width
// - OPERAND_BITS  8   operand field = row count N (0 treated as 1)
// - DRAIN_CYCLES  8   idle cycles after last MAT_MUL/MAT_MUL_ACC row for array drain (0 = none)
// - INST_BITS     OPCODE_BITS+ADDRA_BITS+ADDRB_BITS+OPERAND_BITS; fields MSB->LSB: opcode, addra, addrb, operand
// PORTS
// - clk          in   1             clock, rising edge
// - reset_n      in   1             asynchronous, active-low reset
// - inst_valid   in   1             instruction present
// - inst_ready   out  1             sequencer can accept (comb: state==S_IDLE)
// - instruction  in   INST_BITS     instruction word
// - busy         out  1             burst or drain in progress
// - illegal_op   out  1             1-cycle pulse on accepted undefined opcode
// - read_ub, write_ub, read_wb, write_wb, read_acc, write_acc        out 1 each  buffer strobes
// - data_fifo_en, weight_fifo_en, mmu_load_weight_en, mm_en, acc_en out 1 each  datapath enables
// - addra        out  ADDRA_BITS    current read address
// - addrb        out  ADDRB_BITS    current write address
// - dout         out  OPERAND_BITS  latched operand of current instruction
// BEHAVIOUR
// - Opcodes: 0 IDLE,1 DATA_FIFO,2 WEIGHT_FIFO,3 WRITE_DATA,4 WRITE_WEIGHT,5 WRITE_RESULT,6 LOAD_DATA,7 LOAD_WEIGHT,8 MAT_MUL,9 MAT_MUL_ACC; 10+ illegal.
// - Strobe sets per row: 1 data_fifo_en; 2 weight_fifo_en; 3 write_ub; 4 write_wb; 6 read_ub+data_fifo_en;
//   7 read_wb+weight_fifo_en+mmu_load_weight_en; 8 mm_en+write_acc; 9 mm_en+write_acc+acc_en; 5 see below.
// - All outputs registered; reset: every strobe, busy, illegal_op, addra, addrb, dout = 0; state S_IDLE; inst_ready=1.
// - FSM: S_IDLE, S_EXEC, S_WR_RD, S_WR_WR, S_DRAIN.
// - S_IDLE: handshake (valid&ready) latches addra/addrb/dout, row counter=max(N,1); strobes for row 0 assert next cycle.
//   opcode 0: accepted, no strobes, stays S_IDLE. Illegal: illegal_op pulses next cycle, no strobes, stays S_IDLE.
// - S_EXEC: one row per cycle; after each row addra++, addrb++ (modulo 2^width, wrap silently); counter--.
//   Last row -> S_DRAIN if opcode 8/9 and DRAIN_CYCLES>0, else S_IDLE.
// - WRITE_RESULT: per row S_WR_RD (read_acc at addra) then S_WR_WR (write_ub at addrb, data one cycle behind read);
//   addresses increment after S_WR_WR; 2*N cycles total.
// - S_DRAIN: all strobes 0, busy=1 for DRAIN_CYCLES cycles, then S_IDLE.
// - Latency: accepted at edge k -> first strobe visible after edge k+1; inst_ready returns high cycle after last row/drain.
// - Back-to-back: new instruction accepted in the first S_IDLE cycle; no overlap, no gap beyond that cycle.
// - inst_valid while busy: ignored, instruction must be held by source until ready.
// - Reset mid-burst: all outputs clear immediately (async), remaining rows discarded.
// CONFIGURATION
// - TPU_SEQ_PERF_CNT_EN defined: adds outputs perf_inst_cnt[31:0] (accepted non-IDLE instructions) and
//   perf_busy_cnt[31:0] (cycles with busy=1); both saturate at 2^32-1, cleared by reset_n only.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset then idle: all outputs 0, inst_ready=1, busy=0 held for 10 cycles with inst_valid=0.
// - LOAD_DATA addra=0x10 N=4: read_ub+data_fifo_en 4 cycles, addra 0x10..0x13, ready back on cycle 5.
// - WRITE_RESULT addra=0x00 addrb=0x40 N=2: read_acc@0, write_ub@0x40, read_acc@1, write_ub@0x41 (4 cycles).
// - MAT_MUL_ACC N=3, DRAIN_CYCLES=8: mm_en+write_acc+acc_en 3 cycles, busy 8 more, then ready; N=0 gives 1 row.
// - Wrap/illegal: LOAD_WEIGHT addra=0xFE N=3 -> 0xFE,0xFF,0x00; opcode 0xC -> illegal_op 1 pulse, no strobes.
// - Reset asserted in row 2 of N=5 MAT_MUL: outputs 0 same cycle, next instruction after release runs cleanly.

Source files
------------

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: multi-cycle instruction sequencer for the systolic-array TPU.
// Accepts one instruction per valid/ready handshake and expands it into a
// burst of N row operations. Each row drives buffer/FIFO/MMU/accumulator
// strobes at an auto-incrementing address pair.
// Optional feature macro: TPU_SEQ_PERF_CNT_EN adds saturating performance
// counters (o_perf_inst_cnt, o_perf_busy_cnt).
//
// Timing model: every output is a register loaded from a decode of the
// current state. An instruction accepted at edge k therefore shows its first
// row after edge k+1. A zero-strobe tail cycle in S_EXEC (r_cnt == 0) follows
// the last row, so inst_ready rises the cycle after the last visible row or
// drain cycle.
module tpu_sequencer #(
    parameter int OPCODE_BITS  = 4,
    parameter int ADDRA_BITS   = 8,
    parameter int ADDRB_BITS   = 8,
    parameter int OPERAND_BITS = 8,
    parameter int DRAIN_CYCLES = 8,
    parameter int INST_BITS    = OPCODE_BITS + ADDRA_BITS + ADDRB_BITS + OPERAND_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_inst_valid,
    output logic                    o_inst_ready,
    input  logic [INST_BITS-1:0]    i_instruction,
    output logic                    o_busy,
    output logic                    o_illegal_op,
    output logic                    o_read_ub,
    output logic                    o_write_ub,
    output logic                    o_read_wb,
    output logic                    o_write_wb,
    output logic                    o_read_acc,
    output logic                    o_write_acc,
    output logic                    o_data_fifo_en,
    output logic                    o_weight_fifo_en,
    output logic                    o_mmu_load_weight_en,
    output logic                    o_mm_en,
    output logic                    o_acc_en,
    output logic [ADDRA_BITS-1:0]   o_addra,
    output logic [ADDRB_BITS-1:0]   o_addrb,
    output logic [OPERAND_BITS-1:0] o_dout
`ifdef TPU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]             o_perf_inst_cnt,
    output logic [31:0]             o_perf_busy_cnt
`endif
);

    localparam logic [OPCODE_BITS-1:0] OP_IDLE         = OPCODE_BITS'(0);
    localparam logic [OPCODE_BITS-1:0] OP_DATA_FIFO    = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OP_WEIGHT_FIFO  = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_DATA   = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_WEIGHT = OPCODE_BITS'(4);
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_RESULT = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] OP_LOAD_DATA    = OPCODE_BITS'(6);
    localparam logic [OPCODE_BITS-1:0] OP_LOAD_WEIGHT  = OPCODE_BITS'(7);
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL      = OPCODE_BITS'(8);
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL_ACC  = OPCODE_BITS'(9);

    // Drain counter holds DRAIN_CYCLES-1 down to 0; the first drain cycle is
    // emitted from the S_EXEC tail cycle.
    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam bit             HAS_DRAIN  = (DRAIN_CYCLES > 0);
    localparam logic [DW-1:0]  DRAIN_LOAD = HAS_DRAIN ? DW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WR_RD, S_WR_WR, S_DRAIN} state_t;

    state_t                  r_state, w_next_state;
    logic [OPCODE_BITS-1:0]  r_op;
    logic [ADDRA_BITS-1:0]   r_ptra;
    logic [ADDRB_BITS-1:0]   r_ptrb;
    logic [OPERAND_BITS-1:0] r_cnt;
    logic [OPERAND_BITS-1:0] r_dout;
    logic [DW-1:0]           r_dcnt;

    logic [OPCODE_BITS-1:0]  w_opcode;
    logic [ADDRA_BITS-1:0]   w_addra;
    logic [ADDRB_BITS-1:0]   w_addrb;
    logic [OPERAND_BITS-1:0] w_operand;
    logic                    w_accept, w_legal, w_start, w_to_drain;
    logic w_busy, w_illegal, w_read_ub, w_write_ub, w_read_wb, w_write_wb, w_read_acc;
    logic w_write_acc, w_data_fifo_en, w_weight_fifo_en, w_mmu_load_weight_en, w_mm_en, w_acc_en;

    assign w_opcode   = i_instruction[INST_BITS-1 -: OPCODE_BITS];
    assign w_addra    = i_instruction[ADDRB_BITS+OPERAND_BITS +: ADDRA_BITS];
    assign w_addrb    = i_instruction[OPERAND_BITS +: ADDRB_BITS];
    assign w_operand  = i_instruction[0 +: OPERAND_BITS];

    assign o_inst_ready = (r_state == S_IDLE);
    assign w_accept     = i_inst_valid && o_inst_ready;
    assign w_legal      = (w_opcode <= OP_MAT_MUL_ACC);
    assign w_start      = w_accept && w_legal && (w_opcode != OP_IDLE);
    assign w_to_drain   = HAS_DRAIN && ((r_op == OP_MAT_MUL) || (r_op == OP_MAT_MUL_ACC));
    assign o_dout       = r_dout;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state: rows in S_EXEC, read/write pairs for WRITE_RESULT, optional drain
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start)
                         w_next_state = (w_opcode == OP_WRITE_RESULT) ? S_WR_RD : S_EXEC;
            S_EXEC:  if (r_cnt == '0)
                         w_next_state = w_to_drain ? S_DRAIN : S_IDLE;
            S_WR_RD: w_next_state = S_WR_WR;
            // The last pair falls into the S_EXEC tail with the counter at zero
            S_WR_WR: w_next_state = (r_cnt == OPERAND_BITS'(1)) ? S_EXEC : S_WR_RD;
            S_DRAIN: if (r_dcnt == '0) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Instruction latch, row counter, address pointers and drain counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op   <= '0;
            r_ptra <= '0;
            r_ptrb <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_dcnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op   <= w_opcode;
                    r_ptra <= w_addra;
                    r_ptrb <= w_addrb;
                    r_dout <= w_operand;
                    r_cnt  <= (w_operand == '0) ? OPERAND_BITS'(1) : w_operand;
                end
                S_EXEC: if (r_cnt != '0) begin
                    r_ptra <= r_ptra + ADDRA_BITS'(1);
                    r_ptrb <= r_ptrb + ADDRB_BITS'(1);
                    r_cnt  <= r_cnt - OPERAND_BITS'(1);
                end else if (w_to_drain) begin
                    r_dcnt <= DRAIN_LOAD;
                end
                S_WR_WR: begin
                    r_ptra <= r_ptra + ADDRA_BITS'(1);
                    r_ptrb <= r_ptrb + ADDRB_BITS'(1);
                    r_cnt  <= r_cnt - OPERAND_BITS'(1);
                end
                S_DRAIN: if (r_dcnt != '0) r_dcnt <= r_dcnt - DW'(1);
                default: ;
            endcase
        end
    end

    // Output decode: strobes for the row the current state represents
    always_comb begin
        w_busy = 1'b0;               w_illegal = 1'b0;
        w_read_ub = 1'b0;            w_write_ub = 1'b0;
        w_read_wb = 1'b0;            w_write_wb = 1'b0;
        w_read_acc = 1'b0;           w_write_acc = 1'b0;
        w_data_fifo_en = 1'b0;       w_weight_fifo_en = 1'b0;
        w_mmu_load_weight_en = 1'b0; w_mm_en = 1'b0;
        w_acc_en = 1'b0;
        case (r_state)
            S_IDLE: w_illegal = w_accept && !w_legal;
            S_EXEC: begin
                if (r_cnt != '0) begin
                    w_busy = 1'b1;
                    case (r_op)
                        OP_DATA_FIFO:    w_data_fifo_en = 1'b1;
                        OP_WEIGHT_FIFO:  w_weight_fifo_en = 1'b1;
                        OP_WRITE_DATA:   w_write_ub = 1'b1;
                        OP_WRITE_WEIGHT: w_write_wb = 1'b1;
                        OP_LOAD_DATA: begin
                            w_read_ub = 1'b1;
                            w_data_fifo_en = 1'b1;
                        end
                        OP_LOAD_WEIGHT: begin
                            w_read_wb = 1'b1;
                            w_weight_fifo_en = 1'b1;
                            w_mmu_load_weight_en = 1'b1;
                        end
                        OP_MAT_MUL: begin
                            w_mm_en = 1'b1;
                            w_write_acc = 1'b1;
                        end
                        OP_MAT_MUL_ACC: begin
                            w_mm_en = 1'b1;
                            w_write_acc = 1'b1;
                            w_acc_en = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    // Tail cycle doubles as the first drain cycle
                    w_busy = w_to_drain;
                end
            end
            S_WR_RD: begin
                w_busy = 1'b1;
                w_read_acc = 1'b1;
            end
            S_WR_WR: begin
                w_busy = 1'b1;
                w_write_ub = 1'b1;
            end
            S_DRAIN: w_busy = (r_dcnt != '0);
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_busy <= 1'b0;               o_illegal_op <= 1'b0;
            o_read_ub <= 1'b0;            o_write_ub <= 1'b0;
            o_read_wb <= 1'b0;            o_write_wb <= 1'b0;
            o_read_acc <= 1'b0;           o_write_acc <= 1'b0;
            o_data_fifo_en <= 1'b0;       o_weight_fifo_en <= 1'b0;
            o_mmu_load_weight_en <= 1'b0; o_mm_en <= 1'b0;
            o_acc_en <= 1'b0;
            o_addra <= '0;                o_addrb <= '0;
        end else begin
            o_busy <= w_busy;                             o_illegal_op <= w_illegal;
            o_read_ub <= w_read_ub;                       o_write_ub <= w_write_ub;
            o_read_wb <= w_read_wb;                       o_write_wb <= w_write_wb;
            o_read_acc <= w_read_acc;                     o_write_acc <= w_write_acc;
            o_data_fifo_en <= w_data_fifo_en;             o_weight_fifo_en <= w_weight_fifo_en;
            o_mmu_load_weight_en <= w_mmu_load_weight_en; o_mm_en <= w_mm_en;
            o_acc_en <= w_acc_en;
            o_addra <= r_ptra;                            o_addrb <= r_ptrb;
        end
    end

`ifdef TPU_SEQ_PERF_CNT_EN
    // Saturating counters: accepted non-IDLE instructions and busy cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_perf_inst_cnt <= '0;
            o_perf_busy_cnt <= '0;
        end else begin
            if (w_accept && (w_opcode != OP_IDLE) && (o_perf_inst_cnt != '1))
                o_perf_inst_cnt <= o_perf_inst_cnt + 32'd1;
            if (o_busy && (o_perf_busy_cnt != '1))
                o_perf_busy_cnt <= o_perf_busy_cnt + 32'd1;
        end
    end
`endif

endmodule
